key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//  Debounces NUM_KEYS raw push-button inputs, timed by the 1 ms strobe from the
//  millisecond tick generator (one-cycle pulse every 50000 clk at 50 MHz).
//  Emits clean key levels plus one-cycle press/release pulses to the control
//  FSMs. Sits between the board pins and all user-input consumers.
// PARAMETERS
//  NUM_KEYS       4   number of independent key channels
//  DEBOUNCE_MS    20  stable ms ticks required to accept a change (>=1)
//  LONG_MS        1000 ms ticks held before key_long pulse (macro only, >DEBOUNCE_MS)
//  CNT_W          10  tick counter width; must hold max(DEBOUNCE_MS, LONG_MS)
//  KEY_ACTIVE_LOW 1   1: pin reads 0 when pressed; 0: pin reads 1 when pressed
// PORTS
//  clk          in   1         system clock
//  reset        in   1         asynchronous, active-low reset
//  tick_1ms     in   1         1-cycle strobe, once per ms, synchronous to clk
//  key_in       in   NUM_KEYS  raw asynchronous key pins
//  key_level    out  NUM_KEYS  debounced state, 1 = pressed
//  key_press    out  NUM_KEYS  1-cycle pulse on accepted press
//  key_release  out  NUM_KEYS  1-cycle pulse on accepted release
//  key_long     out  NUM_KEYS  1-cycle long-press pulse (0 if macro off)
// BEHAVIOUR
//  - Reset (reset=0): all state IDLE, counters 0, sync flops 0, all outputs 0,
//    immediately (async); released synchronously with clk.
//  - Input: polarity normalised (inverted if KEY_ACTIVE_LOW), then 2-flop
//    synchroniser per key -> s[i] (1 = pressed). 2-cycle input latency.
//  - Per-key FSM, independent, registered outputs:
//    IDLE:        s=1 -> PRESS_CHK, cnt=0.
//    PRESS_CHK:   s=0 -> IDLE, cnt=0 (bounce). Else on tick cnt++; on tick
//                 where cnt==DEBOUNCE_MS-1 -> HELD, key_level<=1, key_press<=1.
//    HELD:        s=0 -> RELEASE_CHK, cnt=0.
//    RELEASE_CHK: s=1 -> HELD, cnt=0 (glitch). Else on tick cnt++; on tick where
//                 cnt==DEBOUNCE_MS-1 -> IDLE, key_level<=0, key_release<=1.
//  - Accept delay: DEBOUNCE_MS ticks of stable s; actual time DEBOUNCE_MS-1..
//    DEBOUNCE_MS ms because the first tick is unaligned.
//  - s change and tick in same cycle: change wins, tick not counted, cnt=0.
//  - key_press/key_release high exactly one clk, then 0; never both for one key.
//  - Counters saturate, never wrap. tick_1ms held high >1 cycle counts per cycle.
//  - Key held through reset release: debounced anew, key_press after DEBOUNCE_MS.
// CONFIGURATION
//  KEY_LONG_PRESS_EN defined: separate per-key hold counter cleared on entry to
//  HELD, incremented per tick in HELD/RELEASE_CHK, cleared on return to IDLE;
//  on tick where it reaches LONG_MS, key_long pulses 1 cycle, once per press
//  (counter saturates). Glitch back into HELD does not clear it.
//  Undefined: no hold counter logic; key_long tied to 0; all else identical.
// TESTING (NUM_KEYS=4, DEBOUNCE_MS=20, LONG_MS=100, tick every 10 clk)
//  1 key_in[0] pressed clean, held 30 ticks -> key_level[0]=1 after 20th tick,
//    exactly one key_press[0] pulse; keys 1-3 outputs stay 0.
//  2 key_in[1] toggled every 5 ticks for 50 ticks, then held -> no press during
//    bounce; key_press[1] 20 ticks after last edge.
//  3 Held key0 released clean -> key_release[0] single pulse after 20 ticks,
//    key_level[0]=0; key_press[0] not re-asserted.
//  4 Held key0 released for 19 ticks then re-pressed -> no release pulse,
//    key_level[0] stays 1 throughout.
//  5 reset=0 at 10th tick of PRESS_CHK, key still held -> outputs 0 within same
//    cycle; after reset=1, key_press 20 ticks later.
//  6 Macro on, key2 held 150 ticks -> one key_long[2] pulse at 100th tick after
//    entering HELD; macro off -> key_long==0 always.

Source files
------------

// File: rtl/key_debounce_if.sv
// Key debounce bundle: tick strobe and raw pins in, debounced levels and event pulses out.
interface key_debounce_if #(
  parameter int NUM_KEYS = 4
);
  logic                tick_1ms;
  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_long;

  modport master (
    output tick_1ms, key_in,
    input  key_level, key_press, key_release, key_long
  );

  modport slave (
    input  tick_1ms, key_in,
    output key_level, key_press, key_release, key_long
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key 2-flop sync + debounce FSM on tick_1ms; registered level/press/release (+key_long under KEY_LONG_PRESS_EN).
// Latency: 2 clk sync + DEBOUNCE_MS stable ticks; free-running, no backpressure.
module key_debounce #(
  parameter int NUM_KEYS       = 4,
  parameter int DEBOUNCE_MS    = 20,
`ifdef KEY_LONG_PRESS_EN
  parameter int LONG_MS        = 1000,
`endif
  parameter int CNT_W          = 10,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  key_debounce_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t              state_q [NUM_KEYS];
  state_t              state_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0] sync1_q, s_q;
  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] key_norm;

  assign key_norm = KEY_ACTIVE_LOW ? ~bus.key_in : bus.key_in;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      s_q       <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= key_norm;
      s_q       <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // A change of s always takes priority over a coincident tick.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (s_q[i]) begin
            state_d[i] = PRESS_CHK;
            cnt_d[i]   = '0;
          end
        end
        PRESS_CHK: begin
          if (!s_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (bus.tick_1ms) begin
            if (cnt_q[i] == DEB_LAST) begin
              state_d[i] = HELD;
              cnt_d[i]   = '0;
              level_d[i] = 1'b1;
              press_d[i] = 1'b1;
            end else begin
              cnt_d[i] = sat_inc(cnt_q[i]);
            end
          end
        end
        HELD: begin
          if (!s_q[i]) begin
            state_d[i] = RELEASE_CHK;
            cnt_d[i]   = '0;
          end
        end
        RELEASE_CHK: begin
          if (s_q[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (bus.tick_1ms) begin
            if (cnt_q[i] == DEB_LAST) begin
              state_d[i]   = IDLE;
              cnt_d[i]     = '0;
              level_d[i]   = 1'b0;
              release_d[i] = 1'b1;
            end else begin
              cnt_d[i] = sat_inc(cnt_q[i]);
            end
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign bus.key_level   = level_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_TGT = CNT_W'(LONG_MS);

  logic [CNT_W-1:0]    hold_q [NUM_KEYS];
  logic [CNT_W-1:0]    hold_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] long_q, long_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      long_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) hold_q[i] <= '0;
    end else begin
      long_q <= long_d;
      for (int i = 0; i < NUM_KEYS; i++) hold_q[i] <= hold_d[i];
    end
  end

  // Hold time survives a release glitch; it parks at LONG_TGT so key_long fires once per press.
  always_comb begin
    long_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hold_d[i] = hold_q[i];
      if (state_d[i] == IDLE || (state_q[i] == PRESS_CHK && state_d[i] == HELD)) begin
        hold_d[i] = '0;
      end else if ((state_q[i] == HELD || state_q[i] == RELEASE_CHK) && bus.tick_1ms &&
                   hold_q[i] != LONG_TGT) begin
        hold_d[i] = hold_q[i] + 1'b1;
        long_d[i] = (hold_q[i] == LONG_TGT - 1'b1);
      end
    end
  end

  assign bus.key_long = long_q;
`else
  assign bus.key_long = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: 10-clk tick, active-low pins, event scoreboard plus table-driven level vectors.
module tb_key_debounce;
  localparam int NK  = 4;
  localparam int DEB = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  key_debounce_if #(.NUM_KEYS(NK)) bus ();

  key_debounce #(
`ifdef KEY_LONG_PRESS_EN
    .LONG_MS(100),
`endif
    .NUM_KEYS(NK),
    .DEBOUNCE_MS(DEB),
    .CNT_W(10),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;  // 0 press, 1 release, 2 long
    int key;
    int tick;
  } ev_t;

  typedef struct {
    logic [NK-1:0] pressed;
    int            ticks;
    logic [NK-1:0] exp_level;
  } vec_t;

  ev_t           sb[$];
  vec_t          vecs[5];
  int            ntick  = 0;
  int            phase  = 0;
  int            checks = 0;
  int            errors = 0;
  logic [NK-1:0] pressed = '0;
  int            t0;

  // Tick strobe: one clk high every 10 clk; ntick counts strobes issued.
  initial begin
    bus.tick_1ms = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phase = (phase == 9) ? 0 : phase + 1;
      bus.tick_1ms = (phase == 9);
      if (phase == 9) ntick++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, ntick);
    end
  endtask

  task automatic sb_hit(input int kind, input int key);
    int idx = -1;
    for (int j = 0; j < sb.size(); j++)
      if (idx < 0 && sb[j].kind == kind && sb[j].key == key) idx = j;
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL sb_unexpected: pulse kind=%0d key=%0d at tick %0d, expected none", kind, key, ntick);
    end else begin
      if (sb[idx].tick != ntick) begin
        errors++;
        $display("FAIL sb_timing: kind=%0d key=%0d got tick %0d expected tick %0d",
                 kind, key, ntick, sb[idx].tick);
      end
      sb.delete(idx);
    end
  endtask

  task automatic sb_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: pending events got %0d expected 0 (first kind=%0d key=%0d tick=%0d)",
               name, sb.size(), sb[0].kind, sb[0].key, sb[0].tick);
      sb.delete();
    end
  endtask

  // Pulse monitor: every pulse must match an expected event at the expected tick.
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < NK; k++) begin
        if (bus.key_press[k])   sb_hit(0, k);
        if (bus.key_release[k]) sb_hit(1, k);
        if (bus.key_long[k])    sb_hit(2, k);
      end
    end
  end

  task automatic drive_raw(input logic [NK-1:0] v);
    bus.key_in = ~v;
  endtask

  // Change the accepted key state: each changed key must produce its pulse DEB ticks later.
  task automatic set_keys(input logic [NK-1:0] v);
    for (int k = 0; k < NK; k++)
      if (v[k] != pressed[k]) sb.push_back('{v[k] ? 0 : 1, k, ntick + DEB});
    pressed = v;
    drive_raw(v);
  endtask

  // Return at the first negedge after strobe 'target' has been sampled by the DUT.
  task automatic wait_tick(input int target);
    int guard = 0;
    while (ntick < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) begin
      checks++;
      errors++;
      $display("FAIL wait_tick: timeout at tick %0d expected to reach %0d", ntick, target);
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at tick %0d", ntick);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0101, 22, 4'b0101};
    vecs[1] = '{4'b0110, 22, 4'b0110};
    vecs[2] = '{4'b1111, 22, 4'b1111};
    vecs[3] = '{4'b1010, 25, 4'b1010};
    vecs[4] = '{4'b0000, 22, 4'b0000};

    drive_raw('0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level",   bus.key_level,   0);
    chk("rst_press",   bus.key_press,   0);
    chk("rst_release", bus.key_release, 0);
    chk("rst_long",    bus.key_long,    0);
    reset = 1'b1;
    wait_tick(ntick + 2);

    // Clean press of key0
    set_keys(4'b0001);
    t0 = ntick;
    wait_tick(t0 + 19); chk("t1_before_accept", bus.key_level, 4'b0000);
    wait_tick(t0 + 20); chk("t1_accept",        bus.key_level, 4'b0001);
    wait_tick(t0 + 30); chk("t1_held",          bus.key_level, 4'b0001);
    sb_empty("t1_events");

    // Clean release of key0
    set_keys(4'b0000);
    t0 = ntick;
    wait_tick(t0 + 19); chk("t3_before_accept", bus.key_level, 4'b0001);
    wait_tick(t0 + 20); chk("t3_accept",        bus.key_level, 4'b0000);
    wait_tick(t0 + 25);
    sb_empty("t3_events");

    // Key1 bouncing every 5 ticks, then held
    t0 = ntick;
    for (int k = 0; k < 10; k++) begin
      drive_raw((k % 2 == 0) ? 4'b0010 : 4'b0000);
      wait_tick(t0 + 5 * (k + 1));
    end
    chk("t2_bounce_level", bus.key_level, 4'b0000);
    set_keys(4'b0010);
    t0 = ntick;
    wait_tick(t0 + 19); chk("t2_before_accept", bus.key_level, 4'b0000);
    wait_tick(t0 + 20); chk("t2_accept",        bus.key_level, 4'b0010);
    set_keys(4'b0000);
    wait_tick(ntick + 22);
    sb_empty("t2_events");

    // Key0 held, released 19 ticks, re-pressed: no release
    set_keys(4'b0001);
    wait_tick(ntick + 22);
    sb_empty("t4_press");
    drive_raw(4'b0000);
    t0 = ntick;
    wait_tick(t0 + 10); chk("t4_glitch_mid",  bus.key_level, 4'b0001);
    wait_tick(t0 + 19); chk("t4_glitch_last", bus.key_level, 4'b0001);
    drive_raw(4'b0001);
    wait_tick(t0 + 30); chk("t4_after",       bus.key_level, 4'b0001);
    sb_empty("t4_events");

    // Reset mid-debounce of key3 while key0 is held; both re-debounced afterwards
    drive_raw(4'b1001);
    t0 = ntick;
    wait_tick(t0 + 10);
    reset = 1'b0;
    #1;
    chk("t5_async_level", bus.key_level, 4'b0000);
    chk("t5_async_press", bus.key_press, 4'b0000);
    wait_tick(t0 + 12);
    reset   = 1'b1;
    pressed = '0;
    set_keys(4'b1001);
    t0 = ntick;
    wait_tick(t0 + 19); chk("t5_before_accept", bus.key_level, 4'b0000);
    wait_tick(t0 + 20); chk("t5_accept",        bus.key_level, 4'b1001);
    set_keys(4'b0000);
    wait_tick(ntick + 22);
    sb_empty("t5_events");

    // Table-driven multi-key patterns
    for (int v = 0; v < 5; v++) begin
      set_keys(vecs[v].pressed);
      t0 = ntick;
      wait_tick(t0 + vecs[v].ticks);
      chk($sformatf("vec%0d_level", v), bus.key_level, vecs[v].exp_level);
      sb_empty($sformatf("vec%0d_events", v));
    end

    // Long hold of key2
    set_keys(4'b0100);
    t0 = ntick;
`ifdef KEY_LONG_PRESS_EN
    sb.push_back('{2, 2, t0 + DEB + 100});
`endif
    wait_tick(t0 + 150);
    chk("t6_level", bus.key_level, 4'b0100);
    chk("t6_long_idle", bus.key_long, 4'b0000);
    set_keys(4'b0000);
    wait_tick(ntick + 22);
    chk("t6_release_level", bus.key_level, 4'b0000);
    sb_empty("t6_events");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
